// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - direct-form symmetric low-pass FIR with registered full-precision output
module fir_filter #(
  parameter int N1 = 8,
  parameter int N2 = 16,
  parameter int N3 = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic signed [N2-1:0] input_data,
  output logic signed [N3-1:0] output_data,
  output logic signed [N2-1:0] sampleT
);

  function automatic logic signed [N2-1:0] coef(input int k);
    case (k)
      0, 7:    coef = N2'(5);
      1, 6:    coef = N2'(17);
      2, 5:    coef = N2'(42);
      default: coef = N2'(72);
    endcase
  endfunction

  logic signed [N2-1:0] x_q [N1];
  logic signed [N2-1:0] x_d [N1];
  logic signed [N3-1:0] out_q;
  logic signed [N3-1:0] out_d;
  logic signed [N3-1:0] sum;

  // Sum of products over the pre-edge delay line; wraps modulo 2^N3.
  always_comb begin
    logic signed [2*N2-1:0] prod;
    sum  = '0;
    prod = '0;
    for (int k = 0; k < N1; k++) begin
      prod = x_q[k] * coef(k);
      sum  = sum + N3'(prod);
    end
  end

  always_comb begin
    x_d   = x_q;
    out_d = out_q;
    if (enable) begin
      x_d[0] = input_data;
      for (int k = 1; k < N1; k++) x_d[k] = x_q[k-1];
      out_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N1; k++) x_q[k] <= '0;
      out_q <= '0;
    end else begin
      x_q   <= x_d;
      out_q <= out_d;
    end
  end

  assign output_data = out_q;
  assign sampleT     = x_q[0];

endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - directed and randomized checks of fir_filter against a sample-history model
module tb_fir_filter;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] input_data = '0;
  logic signed [31:0] output_data;
  logic signed [15:0] sampleT;

  int vectors = 0;
  int miscompares = 0;

  int coefs [8] = '{5, 17, 42, 72, 72, 42, 17, 5};
  int impulse_exp [9] = '{5, 17, 42, 72, 72, 42, 17, 5, 0};
  int step_exp [8] = '{5, 22, 64, 136, 208, 250, 267, 272};

  int hist[$];
  int exp_out = 0;

  fir_filter #(.N1(8), .N2(16), .N3(32)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .input_data(input_data), .output_data(output_data), .sampleT(sampleT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Output is the coefficient-weighted sum of the most recent eight accepted samples.
  function automatic int model_sum();
    longint s = 0;
    for (int k = 0; k < 8 && k < hist.size(); k++) s += longint'(coefs[k]) * longint'(hist[k]);
    return int'(s);
  endfunction

  function automatic int model_latest();
    return (hist.size() > 0) ? hist[0] : 0;
  endfunction

  task automatic apply(input logic en, input int d);
    enable = en;
    input_data = 16'(d);
    @(posedge clk);
    #1;
    if (en) begin
      exp_out = model_sum();
      hist.push_front(d);
      if (hist.size() > 8) void'(hist.pop_back());
    end
    chk("model_out", output_data, exp_out);
    chk("model_sampleT", sampleT, model_latest());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_immediate", output_data, 0);
    chk("rst_smp_immediate", sampleT, 0);
    enable = 1'b1;
    input_data = 16'sh1234;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_out", output_data, 0);
    chk("rst_held_smp", sampleT, 0);
    hist.delete();
    exp_out = 0;
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_out", output_data, 0);
    chk("reset_smp", sampleT, 0);
    do_reset();

    // Impulse response
    apply(1'b1, 1);
    chk("impulse_smp", sampleT, 1);
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 0);
      chk($sformatf("impulse_%0d", i), output_data, impulse_exp[i]);
    end

    // Step response
    do_reset();
    apply(1'b1, 1);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1);
      chk($sformatf("step_%0d", i), output_data, step_exp[i]);
    end
    repeat (2) begin
      apply(1'b1, 1);
      chk("step_steady", output_data, 272);
    end

    // Negative full scale
    do_reset();
    repeat (10) apply(1'b1, -32768);
    chk("neg_full_scale", output_data, -8912896);

    // Enable gap mid-response
    do_reset();
    apply(1'b1, 1);
    apply(1'b1, 0);
    apply(1'b1, 0);
    chk("gap_before", output_data, 17);
    repeat (3) begin
      apply(1'b0, int'($urandom_range(0, 65535)) - 32768);
      chk("gap_frozen_out", output_data, 17);
      chk("gap_frozen_smp", sampleT, 0);
    end
    apply(1'b1, 0);
    chk("gap_resume_42", output_data, 42);
    apply(1'b1, 0);
    chk("gap_resume_72", output_data, 72);

    // Async reset during a step response, then restart
    for (int i = 0; i < 4; i++) apply(1'b1, 1);
    do_reset();
    apply(1'b1, 1);
    chk("rst_restart_first", output_data, 0);
    apply(1'b1, 1);
    chk("rst_restart_5", output_data, 5);
    apply(1'b1, 1);
    chk("rst_restart_22", output_data, 22);

    // Alternating +1/-1 cancels in steady state
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, (i % 2 == 0) ? 1 : -1);
      if (i >= 8) chk("alternating_zero", output_data, 0);
    end

    // Randomized samples and enables
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)) - 32768);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
